counter_mod6: RTL and testbench

//  - Synchronous, loadable, modulo-6 down counter (BCD-coded, values 0..5).
//  - Serves as the tens-of-seconds digit of the microwave MS_Timer.
//  - Cascades with a mod-10 units digit: its enab input comes from the

---
 rtl/counter_mod6.sv | 68 ++++++
 tb/tb_counter_mod6.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_mod6.sv
// counter_mod6 -- loadable modulo-MOD down counter (BCD digit, 0..MOD-1).
//
// Tens-of-seconds digit of the microwave timer. It steps down once per clock
// while enab is high (enab comes from the units digit's tc). Its tc output
// pulses while it sits at 0 with enab high, so the next-higher stage
// decrements on the same edge where this one wraps back to MOD-1.
//
// Ports
//   clk           in   1      rising-edge clock
//   clear         in   1      synchronous active-low reset, forces count to 0
//   load          in   1      synchronous active-low parallel load of numero
//   enab          in   1      count enable, active-high
//   numero        in   WIDTH  value to load (values above MOD-1 saturate)
//   numero_saida  out  WIDTH  current count (registered)
//   tc            out  1      terminal count: enab && count == 0
//   zero          out  1      count == 0, independent of enab
//
// Priority on each rising edge: clear, then load, then enab, else hold.

module counter_mod6 #(
    parameter int MOD   = 6,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic             enab,
    input  logic [WIDTH-1:0] numero,
    output logic [WIDTH-1:0] numero_saida,
    output logic             tc,
    output logic             zero
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             count_is_zero;

    assign count_is_zero = (count_q == '0);

    // Next-count logic for the non-reset cases; clear is applied in the
    // register itself so it always wins over load and enab.
    always_comb begin
        count_d = count_q;
        if (!load) begin
            // Out-of-range load values clamp so the digit never leaves 0..MOD-1.
            count_d = (numero > MAX_VAL) ? MAX_VAL : numero;
        end else if (enab) begin
            count_d = count_is_zero ? MAX_VAL : (count_q - ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign numero_saida = count_q;
    assign zero         = count_is_zero;
    // Asserted in the cycle before the 0 -> MOD-1 wrap.
    assign tc           = enab & count_is_zero;

endmodule

// File: tb/tb_counter_mod6.sv
// Directed testbench for counter_mod6: each task drives one scenario and
// checks numero_saida / zero / tc against hand-computed values.

module tb_counter_mod6;

    logic       clk;
    logic       clear;
    logic       load;
    logic       enab;
    logic [3:0] numero;
    logic [3:0] numero_saida;
    logic       tc;
    logic       zero;

    int errors = 0;
    int checks = 0;

    counter_mod6 #(.MOD(6), .WIDTH(4)) dut (
        .clk          (clk),
        .clear        (clear),
        .load         (load),
        .enab         (enab),
        .numero       (numero),
        .numero_saida (numero_saida),
        .tc           (tc),
        .zero         (zero)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle #1 before sampling or re-driving inputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear  = 1'b0;
        load   = 1'b1;
        enab   = 1'b0;
        numero = 4'd0;
        tick();
        checks++;
        if (numero_saida !== 4'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", numero_saida);
        end
        checks++;
        if (zero !== 1'b1) begin
            errors++;
            $display("FAIL reset_zero: got %b expected 1", zero);
        end
        checks++;
        if (tc !== 1'b0) begin
            errors++;
            $display("FAIL reset_tc_enab0: got %b expected 0", tc);
        end
        enab = 1'b1;
        #1;
        checks++;
        if (tc !== 1'b1) begin
            errors++;
            $display("FAIL reset_tc_enab1: got %b expected 1", tc);
        end
        enab  = 1'b0;
        clear = 1'b1;
    endtask

    task automatic test_count_wrap();
        logic [3:0] exp_seq [7];
        exp_seq = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd5};
        enab = 1'b1;
        load = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (numero_saida !== exp_seq[i]) begin
                errors++;
                $display("FAIL wrap_count[%0d]: got %0d expected %0d", i, numero_saida, exp_seq[i]);
            end
            checks++;
            if (tc !== (exp_seq[i] == 4'd0)) begin
                errors++;
                $display("FAIL wrap_tc[%0d]: got %b expected %b", i, tc, (exp_seq[i] == 4'd0));
            end
        end
        enab = 1'b0;
    endtask

    task automatic test_load();
        logic [3:0] exp_seq [3];
        exp_seq = '{4'd2, 4'd1, 4'd0};
        load   = 1'b0;
        numero = 4'd3;
        tick();
        checks++;
        if (numero_saida !== 4'd3) begin
            errors++;
            $display("FAIL load_3: got %0d expected 3", numero_saida);
        end
        load   = 1'b1;
        numero = 4'd4;  // must be ignored while load is high
        enab   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (numero_saida !== exp_seq[i]) begin
                errors++;
                $display("FAIL load_dec[%0d]: got %0d expected %0d", i, numero_saida, exp_seq[i]);
            end
            checks++;
            if (tc !== (exp_seq[i] == 4'd0)) begin
                errors++;
                $display("FAIL load_tc[%0d]: got %b expected %b", i, tc, (exp_seq[i] == 4'd0));
            end
        end
        enab = 1'b0;
    endtask

    task automatic test_saturation();
        logic [3:0] vals [4];
        logic [3:0] exps [4];
        logic       enabs [4];
        vals  = '{4'd9, 4'd15, 4'd2, 4'd6};
        exps  = '{4'd5, 4'd5,  4'd2, 4'd5};
        enabs = '{1'b0, 1'b0,  1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            load   = 1'b0;
            numero = vals[i];
            enab   = enabs[i];
            tick();
            checks++;
            if (numero_saida !== exps[i]) begin
                errors++;
                $display("FAIL sat_load[%0d] numero=%0d: got %0d expected %0d", i, vals[i], numero_saida, exps[i]);
            end
        end
        // Return to 0 for the hold test.
        numero = 4'd0;
        enab   = 1'b0;
        tick();
        load = 1'b1;
        checks++;
        if (numero_saida !== 4'd0) begin
            errors++;
            $display("FAIL sat_load0: got %0d expected 0", numero_saida);
        end
    endtask

    task automatic test_hold_zero();
        enab = 1'b0;
        load = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (numero_saida !== 4'd0 || zero !== 1'b1 || tc !== 1'b0) begin
                errors++;
                $display("FAIL hold_zero[%0d]: got count=%0d zero=%b tc=%b expected 0/1/0", i, numero_saida, zero, tc);
            end
        end
    endtask

    task automatic test_clear_priority();
        load   = 1'b0;
        numero = 4'd2;
        tick();
        checks++;
        if (numero_saida !== 4'd2 || zero !== 1'b0) begin
            errors++;
            $display("FAIL clrpri_pre: got count=%0d zero=%b expected 2/0", numero_saida, zero);
        end
        clear  = 1'b0;
        numero = 4'd4;
        tick();
        checks++;
        if (numero_saida !== 4'd0) begin
            errors++;
            $display("FAIL clrpri_clear_vs_load: got %0d expected 0", numero_saida);
        end
        clear = 1'b1;
        load  = 1'b1;
    endtask

    task automatic test_back_to_back();
        // Count down from 5, then abort mid-count with clear while enab is high.
        load   = 1'b0;
        numero = 4'd5;
        tick();
        load = 1'b1;
        enab = 1'b1;
        tick();
        tick();
        checks++;
        if (numero_saida !== 4'd3) begin
            errors++;
            $display("FAIL b2b_mid: got %0d expected 3", numero_saida);
        end
        clear = 1'b0;
        tick();
        checks++;
        if (numero_saida !== 4'd0 || tc !== 1'b1) begin
            errors++;
            $display("FAIL b2b_abort: got count=%0d tc=%b expected 0/1", numero_saida, tc);
        end
        clear = 1'b1;
        tick();
        checks++;
        if (numero_saida !== 4'd5 || tc !== 1'b0) begin
            errors++;
            $display("FAIL b2b_rewrap: got count=%0d tc=%b expected 5/0", numero_saida, tc);
        end
        enab = 1'b0;
    endtask

    initial begin
        clear  = 1'b1;
        load   = 1'b1;
        enab   = 1'b0;
        numero = 4'd0;
        #2;
        test_reset();
        test_count_wrap();
        test_load();
        test_saturation();
        test_hold_zero();
        test_clear_priority();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
